// File: rtl/stepper_phase_seq.sv
// Step-rate generator and 8-state coil-phase sequencer for a 4-wire unipolar stepper.
// Outputs are registered and update one edge after inputs are sampled; stalls when en=0 or period=0.
module stepper_phase_seq #(
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 16
) (
  input  logic                clk,
  input  logic                res,
  input  logic                en,
  input  logic                dir,
  input  logic                half_mode,
  input  logic [PERIOD_W-1:0] period,
  output logic [3:0]          phase,
  output logic                step_pulse,
  output logic [POS_W-1:0]    pos
);

  logic [PERIOD_W-1:0] cnt;
  logic [2:0]          idx;
  logic [2:0]          idx_next;
  logic [2:0]          step;
  logic                tick;

  function automatic logic [3:0] phase_lut(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b0011;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b1100;
      3'd6:    p = 4'b1000;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // >= rather than == so a period lowered below the running count fires at once.
  always_comb begin
    tick     = en && (period != '0) && (cnt >= period - PERIOD_W'(1));
    step     = (half_mode || idx[0]) ? 3'd1 : 3'd2;
    idx_next = idx;
    if (tick) begin
      idx_next = dir ? idx + step : idx - step;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt        <= '0;
      idx        <= '0;
      pos        <= '0;
      phase      <= 4'b0000;
      step_pulse <= 1'b0;
    end else begin
      if (!en || (period == '0) || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end
      idx <= idx_next;
      if (tick) begin
        pos <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
      end
      phase      <= en ? phase_lut(idx_next) : 4'b0000;
      step_pulse <= tick;
    end
  end

endmodule
